// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR recovery controller and the voter checker.
package tmr_pkg;

    localparam int unsigned NHARTS_DEFAULT = 3;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StHalt,
        StSync,
        StResume,
        StFatal
    } tmr_rec_state_e;

    function automatic logic popcount_is_one(input logic [NHARTS_DEFAULT-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NHARTS_DEFAULT; i++) begin
            n += 32'(v[i]);
        end
        return n == 1;
    endfunction

endpackage

// File: rtl/tmr_recovery_ctrl_if.sv
// Voter-side inputs and cluster debug/interconnect gating outputs of the recovery controller.
interface tmr_recovery_ctrl_if
    import tmr_pkg::*;
#(
    parameter int unsigned NHARTS = NHARTS_DEFAULT
);
    logic              error;
    logic [NHARTS-1:0] error_id;
    logic              bus_idle;
    logic [NHARTS-1:0] halted;
    logic              sync_done;
    logic              block_req;
    logic [NHARTS-1:0] debug_req;
    logic              sync_req;
    logic [NHARTS-1:0] sync_hart;

    modport master (
        input  error, error_id, bus_idle, halted, sync_done,
        output block_req, debug_req, sync_req, sync_hart
    );

    modport slave (
        output error, error_id, bus_idle, halted, sync_done,
        input  block_req, debug_req, sync_req, sync_hart
    );
endinterface

// File: rtl/tmr_err_counter.sv
// Saturating per-hart error counter; clear takes priority over increment.
module tmr_err_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// Recovery sequencer: drain buses, halt harts, resync the faulty hart, resume;
// escalates to a sticky fatal state on no-majority errors or ack timeouts.
module tmr_recovery_ctrl
    import tmr_pkg::*;
#(
    parameter int unsigned NHARTS  = NHARTS_DEFAULT,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    tmr_recovery_ctrl_if.master     bus,
    input  logic                    clr_cnt_i,
    output logic                    recovering_o,
    output logic                    fatal_o,
    output logic [NHARTS*CNT_W-1:0] err_count_o
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    tmr_rec_state_e    state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [NHARTS-1:0] hart_q, hart_d;
    logic              block_req_q, sync_req_q, recovering_q, fatal_q;
    logic [NHARTS-1:0] debug_req_q;
    logic              start;
    logic              tmo_hit;

    assign start   = (state_q == StIdle) && bus.error && popcount_is_one(bus.error_id);
    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        hart_d  = hart_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    hart_d  = bus.error_id;
                    state_d = StDrain;
                end else if (bus.error) begin
                    state_d = StFatal;
                end
            end
            StDrain:  if (bus.bus_idle) state_d = StHalt;
            StHalt: begin
                if (&bus.halted)  state_d = StSync;
                else if (tmo_hit) state_d = StFatal;
            end
            StSync:   if (bus.sync_done) state_d = StResume;
            StResume: begin
                if (~|bus.halted) begin
                    state_d = StIdle;
                    hart_d  = '0;
                end else if (tmo_hit) begin
                    state_d = StFatal;
                end
            end
            StFatal:  state_d = StFatal;
            default:  state_d = StFatal;
        endcase
    end

    // Timeout only counts while waiting on halt/resume acks and restarts on any state change.
    always_comb begin
        tmo_d = '0;
        if ((state_d == state_q) && ((state_q == StHalt) || (state_q == StResume))) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            tmo_q        <= '0;
            hart_q       <= '0;
            block_req_q  <= 1'b0;
            debug_req_q  <= '0;
            sync_req_q   <= 1'b0;
            recovering_q <= 1'b0;
            fatal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            hart_q       <= hart_d;
            block_req_q  <= (state_d != StIdle);
            debug_req_q  <= {NHARTS{state_d inside {StHalt, StSync, StFatal}}};
            sync_req_q   <= (state_d == StSync);
            recovering_q <= state_d inside {StDrain, StHalt, StSync, StResume};
            fatal_q      <= (state_d == StFatal);
        end
    end

    assign bus.block_req = block_req_q;
    assign bus.debug_req = debug_req_q;
    assign bus.sync_req  = sync_req_q;
    assign bus.sync_hart = hart_q;
    assign recovering_o  = recovering_q;
    assign fatal_o       = fatal_q;

    for (genvar h = 0; h < NHARTS; h++) begin : g_cnt
        tmr_err_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc_i  (start && bus.error_id[h]),
            .clr_i  (clr_cnt_i),
            .count_o(err_count_o[h*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Vector table plus scoreboard queue for the TMR recovery controller (CNT_W=2, TIMEOUT=16).
module tb_tmr_recovery_ctrl;

    localparam int SI = 0, SD = 1, SH = 2, SS = 3, SR = 4, SF = 5;

    typedef struct {
        logic       err;
        logic [2:0] id;
        logic       idle;
        logic [2:0] halted;
        logic       done;
        logic       clr;
        int         st;
        logic [2:0] shart;
        logic [5:0] cnt;
    } vec_t;

    logic       clk;
    logic       rst_ni;
    logic       clr_cnt;
    logic       recovering;
    logic       fatal;
    logic [5:0] err_count;

    int n_vec = 0;
    int n_bad = 0;
    int idx   = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    tmr_recovery_ctrl_if #(.NHARTS(3)) bus ();

    tmr_recovery_ctrl #(
        .NHARTS (3),
        .CNT_W  (2),
        .TIMEOUT(16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .clr_cnt_i   (clr_cnt),
        .recovering_o(recovering),
        .fatal_o     (fatal),
        .err_count_o (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic err, input logic [2:0] id, input logic idle,
                                input logic [2:0] halted, input logic done, input logic clr,
                                input int st, input logic [2:0] shart, input logic [5:0] cnt);
        vec_t v;
        v.err = err; v.id = id; v.idle = idle; v.halted = halted; v.done = done; v.clr = clr;
        v.st = st; v.shart = shart; v.cnt = cnt;
        return v;
    endfunction

    task automatic cmp(input string tag, input logic [5:0] act, input logic [5:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic check(input string tag, input vec_t v);
        logic hold;
        logic rec;
        hold = (v.st == SH) || (v.st == SS) || (v.st == SF);
        rec  = (v.st == SD) || (v.st == SH) || (v.st == SS) || (v.st == SR);
        n_vec++;
        cmp({tag, " block_req"},  6'(bus.block_req), 6'(v.st != SI));
        cmp({tag, " debug_req"},  6'(bus.debug_req), hold ? 6'd7 : 6'd0);
        cmp({tag, " sync_req"},   6'(bus.sync_req),  6'(v.st == SS));
        cmp({tag, " sync_hart"},  6'(bus.sync_hart), 6'(v.shart));
        cmp({tag, " recovering"}, 6'(recovering),    6'(rec));
        cmp({tag, " fatal"},      6'(fatal),         6'(v.st == SF));
        cmp({tag, " err_count"},  err_count,         v.cnt);
    endtask

    task automatic drive_idle();
        bus.error = 1'b0; bus.error_id = '0; bus.bus_idle = 1'b0;
        bus.halted = '0; bus.sync_done = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        bus.error = v.err; bus.error_id = v.id; bus.bus_idle = v.idle;
        bus.halted = v.halted; bus.sync_done = v.done; clr_cnt = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("v%0d", idx), e);
        idx++;
    endtask

    // Reset asserts at the current time and is checked before any clock edge.
    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        drive_idle();
        #1;
        check(tag, mk(0, 0, 0, 0, 0, 0, SI, 3'b000, 6'b0));
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        drive_idle();

        // single fault on hart 1
        tbl.push_back(mk(1, 3'b010, 1, 3'b000, 0, 0, SD, 3'b010, 6'b000100));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 0, SH, 3'b010, 6'b000100));
        tbl.push_back(mk(0, 3'b000, 1, 3'b111, 0, 0, SS, 3'b010, 6'b000100));
        tbl.push_back(mk(0, 3'b000, 1, 3'b111, 1, 0, SR, 3'b010, 6'b000100));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 0, SI, 3'b000, 6'b000100));
        // hart 2 with a long drain and an error masked during SYNC
        tbl.push_back(mk(1, 3'b100, 0, 3'b000, 0, 0, SD, 3'b100, 6'b010100));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, SD, 3'b100, 6'b010100));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 0, SH, 3'b100, 6'b010100));
        tbl.push_back(mk(0, 3'b000, 1, 3'b111, 0, 0, SS, 3'b100, 6'b010100));
        tbl.push_back(mk(1, 3'b001, 1, 3'b111, 0, 0, SS, 3'b100, 6'b010100));
        tbl.push_back(mk(0, 3'b000, 1, 3'b111, 1, 0, SR, 3'b100, 6'b010100));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 0, SI, 3'b000, 6'b010100));
        // id without error and stray sync_done in IDLE are ignored
        tbl.push_back(mk(0, 3'b011, 1, 3'b000, 1, 0, SI, 3'b000, 6'b010100));
        // clear coincident with a new error: clear wins
        tbl.push_back(mk(1, 3'b100, 1, 3'b000, 0, 1, SD, 3'b100, 6'b000000));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 0, SH, 3'b100, 6'b000000));
        tbl.push_back(mk(0, 3'b000, 1, 3'b111, 0, 0, SS, 3'b100, 6'b000000));
        tbl.push_back(mk(0, 3'b000, 1, 3'b111, 1, 0, SR, 3'b100, 6'b000000));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 0, SI, 3'b000, 6'b000000));

        #2;
        do_reset("reset");
        foreach (tbl[i]) apply(tbl[i]);

        // five recoveries on hart 2 saturate its 2-bit counter at 3
        for (int k = 1; k <= 5; k++) begin
            logic [5:0] c;
            c = {((k > 3) ? 2'd3 : 2'(k)), 4'b0000};
            apply(mk(1, 3'b100, 1, 3'b000, 0, 0, SD, 3'b100, c));
            apply(mk(0, 3'b000, 1, 3'b000, 0, 0, SH, 3'b100, c));
            apply(mk(0, 3'b000, 1, 3'b111, 0, 0, SS, 3'b100, c));
            apply(mk(0, 3'b000, 1, 3'b111, 1, 0, SR, 3'b100, c));
            apply(mk(0, 3'b000, 1, 3'b000, 0, 0, SI, 3'b000, c));
        end

        // halt timeout: FATAL exactly 16 cycles after HALT entry
        apply(mk(1, 3'b001, 1, 3'b000, 0, 0, SD, 3'b001, 6'b110001));
        apply(mk(0, 3'b000, 1, 3'b110, 0, 0, SH, 3'b001, 6'b110001));
        for (int i = 0; i < 15; i++)
            apply(mk(0, 3'b000, 1, 3'b110, 0, 0, SH, 3'b001, 6'b110001));
        apply(mk(0, 3'b000, 1, 3'b110, 0, 0, SF, 3'b001, 6'b110001));
        for (int i = 0; i < 3; i++)
            apply(mk(1, 3'b010, 1, 3'b111, 1, 0, SF, 3'b001, 6'b110001));
        #2;
        do_reset("reset_in_fatal");

        // no majority: two faulty ids, then zero ids
        apply(mk(1, 3'b011, 1, 3'b000, 0, 0, SF, 3'b000, 6'b000000));
        for (int i = 0; i < 3; i++)
            apply(mk(1, 3'b010, 1, 3'b000, 1, 0, SF, 3'b000, 6'b000000));
        #2;
        do_reset("reset_after_nomaj");
        apply(mk(1, 3'b000, 1, 3'b000, 0, 0, SF, 3'b000, 6'b000000));
        #2;
        do_reset("reset_after_zero_id");

        // reset mid-HALT drops debug_req without a clock edge
        apply(mk(1, 3'b010, 1, 3'b000, 0, 0, SD, 3'b010, 6'b000100));
        apply(mk(0, 3'b000, 1, 3'b000, 0, 0, SH, 3'b010, 6'b000100));
        #2;
        do_reset("reset_in_halt");
        apply(mk(0, 3'b000, 1, 3'b000, 0, 0, SI, 3'b000, 6'b000000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tmr_recovery_ctrl.md
# tmr_recovery_ctrl

- Sequences recovery of a triple-redundant core cluster after the TMR voter reports a single-hart mismatch.
- The voter keeps the bus correct by majority. This block then quiesces the voted OBI buses, halts all harts through debug request, and requests a context resynchronisation of the faulty hart from the healthy ones.
- It resumes execution once resync is done and escalates to a sticky fatal error when no majority exists or when a handshake times out.
- It sits between the voter's error outputs and the cluster's debug/interconnect gating.

## Interface
- NHARTS, 3, number of redundant harts (only 3 supported).
- CNT_W, 8, width of each per-hart saturating error counter.
- TIMEOUT, 1024, max cycles to wait for halt/resume acknowledgement.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- error_i  in  1  voter mismatch flag.
- error_id_i  in  NHARTS  voter one-hot faulty-hart indication.
- bus_idle_i  in  1  no outstanding OBI transactions on voted instr/data buses.
- halted_i  in  NHARTS  per-hart debug-mode status.
- sync_done_i  in  1  pulse from the debug resync routine: context copy complete.
- clr_cnt_i  in  1  clear all error counters.
- block_req_o  out  1  gate new voted requests at the interconnect.
- debug_req_o  out  NHARTS  debug halt request, all bits equal.
- sync_req_o  out  1  resync in progress.
- sync_hart_o  out  NHARTS  one-hot hart to be overwritten.
- recovering_o  out  1  FSM not in IDLE or FATAL.
- fatal_o  out  1  sticky unrecoverable error.
- err_count_o  out  NHARTS*CNT_W  per-hart error counts, hart 0 in the LSBs.

## Operation
- FSM states: IDLE, DRAIN, HALT, SYNC, RESUME, FATAL.
- **IDLE**
  - error_i=1 and popcount(error_id_i)==1: latch the id into sync_hart_o, increment that hart's counter, go to DRAIN.
  - error_i=1 and popcount!=1 (0 or ≥2): go to FATAL.
  - error_id_i≠0 with error_i=0 is ignored.
- **DRAIN**: block_req_o=1. When bus_idle_i=1, go to HALT.
- **HALT**
  - block_req_o=1, debug_req_o='1, timeout counter running.
  - halted_i=='1: go to SYNC and clear the timeout counter.
  - Timeout counter reaches TIMEOUT-1 without that: go to FATAL.
- **SYNC**
  - block_req_o=1, debug_req_o='1, sync_req_o=1.
  - sync_done_i=1: go to RESUME.
  - No timeout in SYNC; its duration is software-bounded.
- **RESUME**
  - block_req_o=1, debug_req_o='0.
  - halted_i=='0: go to IDLE and clear sync_hart_o.
  - Timeout as in HALT: go to FATAL.
- **FATAL**
  - fatal_o=1, block_req_o=1, debug_req_o='1.
  - Exits only on reset.
- Errors arriving outside IDLE are masked: no counter change, no re-latch.
- Counters saturate at 2^CNT_W-1 (no wrap).
- clr_cnt_i clears all counters. If it coincides with an increment, clear wins and the result is 0.
- sync_done_i outside SYNC is ignored.

## Timing
- All outputs are registered and decoded from the state register plus latched id.
- Reset values: every output 0, state IDLE, counters 0, timeout counter 0.
- Error sampled at edge N: state is DRAIN and block_req_o=1 from edge N+1, with the counter incremented in the same edge.
- bus_idle_i already 1 at entry: DRAIN lasts exactly 1 cycle; debug_req_o rises at N+2.
- Each wait-state transition takes effect on the edge after its condition is sampled high.
- Minimum recovery with all acks immediate is 4 cycles: DRAIN, HALT, SYNC, RESUME, then IDLE.
- Timeout counter is TIMEOUT-sized (clog2(TIMEOUT) bits), cleared on every state change.
- Reset asserted mid-recovery: immediate return to reset values, and debug_req_o drops asynchronously.

## Structure
- tmr_pkg holds:
  - tmr_rec_state_e enum (6 states, 3-bit encoding);
  - the NHARTS default constant;
  - a popcount-is-one function shared with the voter checker.
- Sub-module tmr_err_counter:
  - one instance per hart;
  - CNT_W saturating counter with inc and clr inputs (clr priority).
- FSM, timeout counter and id latch live in the top.

## Test plan
- Single fault: error_i=1, error_id_i=3'b010, bus_idle_i=1, halted_i=3'b111 next cycle, sync_done_i pulse, halted_i=0.
  - Expect states DRAIN→HALT→SYNC→RESUME→IDLE, sync_hart_o=3'b010, count[1]=1, fatal_o=0.
- No majority: error_i=1, error_id_i=3'b011.
  - Expect fatal_o=1 next cycle and held until rst_ni low; counters unchanged.
- Halt timeout, TIMEOUT=16: halted_i stuck at 3'b110.
  - Expect FATAL exactly 16 cycles after HALT entry.
- Masking and drain: second error (id 3'b001) during SYNC is ignored, count[0]=0. Separately, bus_idle_i held low 5 cycles keeps DRAIN and debug_req_o=0 for those 5 cycles.
- Saturation/clear, CNT_W=2:
  - 5 recoveries on hart 2 give count[2]=3;
  - clr_cnt_i coincident with a new error gives count 0;
  - rst_ni asserted in HALT clears debug_req_o without waiting for a clock edge.
